// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard: forwarding encodings,
// tracker entry layout, stage indices and the pending-flush state.
package hazard_scoreboard_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int STG_E   = 0;
  localparam int STG_M   = 1;
  localparam int STG_W   = 2;
  localparam int NUM_STG = 3;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] wreg;
    logic              late;
  } entry_t;

  typedef enum logic {
    FP_IDLE = 1'b0,
    FP_PEND = 1'b1
  } fp_state_e;

  // Late results (loads, mfc0) normally become forwardable only once they reach W.
  function automatic logic ent_ready(logic late, int stg, bit load_ready_w);
    logic r;
    if (!late) r = (stg == STG_M) || (stg == STG_W);
    else       r = (stg == STG_W) || (!load_ready_w && (stg == STG_M));
    return r;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-facing signal bundle of the hazard scoreboard.
interface hazard_scoreboard_if #(
  parameter int NRD   = 2,
  parameter int RAW   = 5,
  parameter int CNT_W = 32
);
  logic               issue_valid;
  logic               issue_wen;
  logic [RAW-1:0]     issue_wreg;
  logic               issue_load;
  logic [NRD*RAW-1:0] rd_reg;
  logic [NRD-1:0]     rd_used;
  logic [NRD-1:0]     rd_early;
  logic               ext_stall;
  logic               exception;
  logic               mispredict;
  logic [2*NRD-1:0]   fwdD;
  logic [2*NRD-1:0]   fwdE;
  logic               stallF, stallD, stallE, stallM, stallW;
  logic               flushD, flushE, flushM, flushW;
  logic               data_stall;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output issue_valid, issue_wen, issue_wreg, issue_load,
    output rd_reg, rd_used, rd_early, ext_stall, exception, mispredict,
    input  fwdD, fwdE, stallF, stallD, stallE, stallM, stallW,
    input  flushD, flushE, flushM, flushW, data_stall, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_wen, issue_wreg, issue_load,
    input  rd_reg, rd_used, rd_early, ext_stall, exception, mispredict,
    output fwdD, fwdE, stallF, stallD, stallE, stallM, stallW,
    output flushD, flushE, flushM, flushW, data_stall, stall_cnt
  );
endinterface

// File: rtl/hazard_fwd_match.sv
// One D-stage read port: finds the nearest in-flight producer (E > M > W)
// and returns the early forwarding select plus this port's stall request.
module hazard_fwd_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int RAW          = 5,
  parameter bit LOAD_READY_W = 1'b1
) (
  input  logic [RAW-1:0] rd_reg,
  input  logic           rd_used,
  input  logic           rd_early,
  input  entry_t         ent_e,
  input  entry_t         ent_m,
  input  entry_t         ent_w,
  output logic [1:0]     fwd_d,
  output logic           stall
);

  logic [REG_AW-1:0] src;
  logic              hit_e, hit_m, hit_w;
  logic              ready_m, ready_w;

  assign src     = REG_AW'(rd_reg);
  assign hit_e   = rd_used && (src != '0) && ent_e.valid && (ent_e.wreg == src);
  assign hit_m   = rd_used && (src != '0) && ent_m.valid && (ent_m.wreg == src);
  assign hit_w   = rd_used && (src != '0) && ent_w.valid && (ent_w.wreg == src);
  assign ready_m = ent_ready(ent_m.late, STG_M, LOAD_READY_W);
  assign ready_w = ent_ready(ent_w.late, STG_W, LOAD_READY_W);

  // A non-ready M producer is harmless to an E consumer: it is in W by then.
  always_comb begin
    fwd_d = FWD_RF;
    stall = 1'b0;
    if (hit_e) begin
      stall = ent_e.late | rd_early;
    end else if (hit_m) begin
      if (ready_m) fwd_d = FWD_M;
      else         stall = rd_early;
    end else if (hit_w && ready_w) begin
      fwd_d = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipe: E/M/W destination tracker, D/E forwarding,
// RAW stalls, stall/flush vectors and a saturating data-stall counter.
//
//   state   | meaning
//   FP_IDLE | no exception waiting
//   FP_PEND | exception arrived under ext_stall, flush on release
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NRD          = 2,
  parameter int RAW          = 5,
  parameter bit LOAD_READY_W = 1'b1,
  parameter int CNT_W        = 32
) (
  input logic                 clk,
  input logic                 rst,
  hazard_scoreboard_if.slave  hz
);

  fp_state_e          fp_state, fp_next;
  entry_t             ent [NUM_STG];
  logic [NRD-1:0]     port_stall;
  logic [2*NRD-1:0]   fwd_d, fwd_e;
  logic [NRD*RAW-1:0] rd_reg_e;
  logic [NRD-1:0]     rd_used_e;
  logic [CNT_W-1:0]   stall_cnt;
  logic [REG_AW-1:0]  src_e;
  logic               hit_m, hit_w;
  logic               exc_eff, data_stall, flush_e, capture;

  for (genvar i = 0; i < NRD; i++) begin : g_port
    hazard_fwd_match #(.RAW(RAW), .LOAD_READY_W(LOAD_READY_W)) u_match (
      .rd_reg   (hz.rd_reg[i*RAW +: RAW]),
      .rd_used  (hz.rd_used[i]),
      .rd_early (hz.rd_early[i]),
      .ent_e    (ent[STG_E]),
      .ent_m    (ent[STG_M]),
      .ent_w    (ent[STG_W]),
      .fwd_d    (fwd_d[2*i +: 2]),
      .stall    (port_stall[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) fp_state <= FP_IDLE;
    else     fp_state <= fp_next;
  end

  always_comb begin
    fp_next = fp_state;
    case (fp_state)
      FP_IDLE: if (hz.exception && hz.ext_stall) fp_next = FP_PEND;
      FP_PEND: if (!hz.ext_stall)                fp_next = FP_IDLE;
      default: fp_next = FP_IDLE;
    endcase
  end

  always_comb begin
    data_stall    = hz.issue_valid & (|port_stall);
    exc_eff       = (hz.exception | (fp_state == FP_PEND)) & ~hz.ext_stall;
    flush_e       = (data_stall | hz.mispredict | exc_eff) & ~hz.ext_stall;
    hz.data_stall = data_stall;
    hz.stallF     = (hz.ext_stall | data_stall) & ~exc_eff;
    hz.stallD     = hz.ext_stall | data_stall;
    hz.stallE     = hz.ext_stall;
    hz.stallM     = hz.ext_stall;
    hz.stallW     = hz.ext_stall;
    hz.flushD     = (hz.mispredict | exc_eff) & ~hz.ext_stall;
    hz.flushE     = flush_e;
    hz.flushM     = exc_eff;
    hz.flushW     = exc_eff;
  end

  // flush_e already covers data_stall, so a stalled D never enters the tracker.
  assign capture = hz.issue_valid & hz.issue_wen & (hz.issue_wreg != '0) & ~flush_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_STG; s++) ent[s] <= '0;
    end else if (!hz.ext_stall) begin
      if (exc_eff) begin
        for (int s = 0; s < NUM_STG; s++) ent[s] <= '0;
      end else begin
        ent[STG_W] <= ent[STG_M];
        ent[STG_M] <= ent[STG_E];
        if (capture) ent[STG_E] <= '{valid: 1'b1, wreg: REG_AW'(hz.issue_wreg), late: hz.issue_load};
        else         ent[STG_E] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_reg_e  <= '0;
      rd_used_e <= '0;
    end else if (!hz.ext_stall) begin
      rd_reg_e  <= hz.rd_reg;
      rd_used_e <= (flush_e || !hz.issue_valid) ? '0 : hz.rd_used;
    end
  end

  always_comb begin
    fwd_e = '0;
    src_e = '0;
    hit_m = 1'b0;
    hit_w = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      src_e = REG_AW'(rd_reg_e[i*RAW +: RAW]);
      hit_m = rd_used_e[i] && (src_e != '0) && ent[STG_M].valid && (ent[STG_M].wreg == src_e);
      hit_w = rd_used_e[i] && (src_e != '0) && ent[STG_W].valid && (ent[STG_W].wreg == src_e);
      if (hit_m && ent_ready(ent[STG_M].late, STG_M, LOAD_READY_W)) fwd_e[2*i +: 2] = FWD_M;
      else if (hit_w)                                               fwd_e[2*i +: 2] = FWD_W;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                              stall_cnt <= '0;
    else if (data_stall && !hz.ext_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end

  assign hz.fwdD      = fwd_d;
  assign hz.fwdE      = fwd_e;
  assign hz.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: two scoreboards (load results ready in W / in M) driven by
// the same pipeline stimulus, each scenario checked against hand-derived values.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_wen, issue_load;
  logic [4:0] issue_wreg;
  logic [9:0] rd_reg;
  logic [1:0] rd_used, rd_early;
  logic       ext_stall, exception, mispredict;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NRD(2), .RAW(5), .CNT_W(4))  if_a ();
  hazard_scoreboard_if #(.NRD(2), .RAW(5), .CNT_W(32)) if_b ();

  assign if_a.issue_valid = issue_valid;  assign if_b.issue_valid = issue_valid;
  assign if_a.issue_wen   = issue_wen;    assign if_b.issue_wen   = issue_wen;
  assign if_a.issue_wreg  = issue_wreg;   assign if_b.issue_wreg  = issue_wreg;
  assign if_a.issue_load  = issue_load;   assign if_b.issue_load  = issue_load;
  assign if_a.rd_reg      = rd_reg;       assign if_b.rd_reg      = rd_reg;
  assign if_a.rd_used     = rd_used;      assign if_b.rd_used     = rd_used;
  assign if_a.rd_early    = rd_early;     assign if_b.rd_early    = rd_early;
  assign if_a.ext_stall   = ext_stall;    assign if_b.ext_stall   = ext_stall;
  assign if_a.exception   = exception;    assign if_b.exception   = exception;
  assign if_a.mispredict  = mispredict;   assign if_b.mispredict  = mispredict;

  hazard_scoreboard #(.NRD(2), .RAW(5), .LOAD_READY_W(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .hz(if_a)
  );

  hazard_scoreboard #(.NRD(2), .RAW(5), .LOAD_READY_W(1'b0), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .hz(if_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic wen, input logic [4:0] wr, input logic ld,
                       input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic [1:0] early);
    issue_valid = v;  issue_wen = wen;  issue_wreg = wr;  issue_load = ld;
    rd_reg = {s1, s0}; rd_used = used; rd_early = early;
  endtask

  task automatic idle();
    set_d(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00);
    ext_stall = 1'b0; exception = 1'b0; mispredict = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (if_a.stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", if_a.stall_cnt); end
    checks++; if ({if_a.fwdD, if_a.fwdE} !== 8'h00) begin errors++; $display("FAIL rst_fwd: got %h want 00", {if_a.fwdD, if_a.fwdE}); end
    checks++; if ({if_a.stallF, if_a.stallD, if_a.flushD, if_a.flushE, if_a.flushM, if_a.flushW} !== 6'b0)
      begin errors++; $display("FAIL rst_quiet: got %b want 000000", {if_a.stallF, if_a.stallD, if_a.flushD, if_a.flushE, if_a.flushM, if_a.flushW}); end
    ext_stall = 1'b1;
    #1;
    checks++; if ({if_a.stallF, if_a.stallD, if_a.stallE, if_a.stallM, if_a.stallW, if_a.flushD, if_a.flushE, if_a.flushM, if_a.flushW} !== 9'b111110000)
      begin errors++; $display("FAIL rst_ext: got %b want 111110000", {if_a.stallF, if_a.stallD, if_a.stallE, if_a.stallM, if_a.stallW, if_a.flushD, if_a.flushE, if_a.flushM, if_a.flushW}); end
    ext_stall = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00);         // lw r2
    #1;
    checks++; if (if_a.data_stall !== 1'b0) begin errors++; $display("FAIL lu_first: got %b want 0", if_a.data_stall); end
    step();
    set_d(1'b1, 1'b1, 5'd3, 1'b0, 5'd2, 5'd4, 2'b11, 2'b00);         // add r3,r2,r4
    #1;
    checks++; if ({if_a.data_stall, if_a.flushE, if_a.stallF, if_a.stallD} !== 4'b1111)
      begin errors++; $display("FAIL lu_stall: got %b want 1111", {if_a.data_stall, if_a.flushE, if_a.stallF, if_a.stallD}); end
    step();
    #1;
    checks++; if (if_a.data_stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %b want 0", if_a.data_stall); end
    checks++; if (if_a.fwdD[1:0] !== 2'b00) begin errors++; $display("FAIL lu_fwdD_a: got %b want 00", if_a.fwdD[1:0]); end
    checks++; if (if_b.fwdD[1:0] !== 2'b10) begin errors++; $display("FAIL lu_fwdD_b: got %b want 10", if_b.fwdD[1:0]); end
    step();
    set_d(1'b1, 1'b0, 5'd0, 1'b0, 5'd2, 5'd0, 2'b01, 2'b00);         // reader of r2 in D
    #1;
    checks++; if (if_a.fwdE !== 4'b0001) begin errors++; $display("FAIL lu_fwdE: got %b want 0001", if_a.fwdE); end
    checks++; if (if_a.fwdD !== 4'b0001) begin errors++; $display("FAIL lu_fwdD_w: got %b want 0001", if_a.fwdD); end
    checks++; if (if_a.stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", if_a.stall_cnt); end
    step();
  endtask

  task automatic test_early_branch();
    do_reset();
    set_d(1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00);         // add r2
    step();
    set_d(1'b1, 1'b0, 5'd0, 1'b0, 5'd2, 5'd5, 2'b11, 2'b11);         // beq r2,r5
    #1;
    checks++; if (if_a.data_stall !== 1'b1) begin errors++; $display("FAIL br_stall: got %b want 1", if_a.data_stall); end
    step();
    #1;
    checks++; if ({if_a.data_stall, if_a.fwdD} !== 5'b0_0010) begin errors++; $display("FAIL br_fwd: got %b want 00010", {if_a.data_stall, if_a.fwdD}); end
    step();
    do_reset();
    set_d(1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00);         // lw r2
    step();
    set_d(1'b1, 1'b0, 5'd0, 1'b0, 5'd2, 5'd5, 2'b11, 2'b11);
    #1;
    checks++; if (if_b.data_stall !== 1'b1) begin errors++; $display("FAIL brl_stall_b: got %b want 1", if_b.data_stall); end
    step();
    #1;
    checks++; if ({if_b.data_stall, if_b.fwdD} !== 5'b0_0010) begin errors++; $display("FAIL brl_fwd_b: got %b want 00010", {if_b.data_stall, if_b.fwdD}); end
    checks++; if (if_a.data_stall !== 1'b1) begin errors++; $display("FAIL brl_stall_a: got %b want 1", if_a.data_stall); end
    step();
  endtask

  task automatic test_r0();
    do_reset();
    set_d(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00);         // lw r0
    step();
    set_d(1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 5'd0, 2'b11, 2'b01);
    #1;
    checks++; if ({if_a.data_stall, if_a.fwdD} !== 5'b0) begin errors++; $display("FAIL r0_d: got %b want 00000", {if_a.data_stall, if_a.fwdD}); end
    step();
    idle();
    #1;
    checks++; if (if_a.fwdE !== 4'b0000) begin errors++; $display("FAIL r0_e: got %b want 0000", if_a.fwdE); end
    step();
  endtask

  task automatic test_exc_under_stall();
    do_reset();
    set_d(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 5'd0, 2'b00, 2'b00);         // add r7
    step();
    idle();
    ext_stall = 1'b1; exception = 1'b1;
    #1;
    checks++; if ({if_a.flushD, if_a.flushE, if_a.flushM, if_a.flushW, if_a.stallE} !== 5'b00001)
      begin errors++; $display("FAIL exs_held: got %b want 00001", {if_a.flushD, if_a.flushE, if_a.flushM, if_a.flushW, if_a.stallE}); end
    step();
    exception = 1'b0;
    step();
    #1;
    checks++; if (if_a.flushM !== 1'b0) begin errors++; $display("FAIL exs_wait: got %b want 0", if_a.flushM); end
    step();
    ext_stall = 1'b0;
    #1;
    checks++; if ({if_a.flushD, if_a.flushE, if_a.flushM, if_a.flushW, if_a.stallF} !== 5'b11110)
      begin errors++; $display("FAIL exs_apply: got %b want 11110", {if_a.flushD, if_a.flushE, if_a.flushM, if_a.flushW, if_a.stallF}); end
    step();
    set_d(1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0, 2'b01, 2'b01);         // branch on r7
    #1;
    checks++; if ({if_a.flushM, if_a.flushD} !== 2'b00) begin errors++; $display("FAIL exs_once: got %b want 00", {if_a.flushM, if_a.flushD}); end
    checks++; if ({if_a.data_stall, if_a.fwdD} !== 5'b0) begin errors++; $display("FAIL exs_inval: got %b want 00000", {if_a.data_stall, if_a.fwdD}); end
    step();
  endtask

  task automatic test_simultaneous();
    do_reset();
    mispredict = 1'b1; exception = 1'b1;
    #1;
    checks++; if ({if_a.flushD, if_a.flushE, if_a.flushM, if_a.flushW, if_a.stallF} !== 5'b11110)
      begin errors++; $display("FAIL mis_exc: got %b want 11110", {if_a.flushD, if_a.flushE, if_a.flushM, if_a.flushW, if_a.stallF}); end
    step();
    idle();
    set_d(1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00);         // lw r2
    step();
    set_d(1'b1, 1'b1, 5'd3, 1'b0, 5'd2, 5'd0, 2'b01, 2'b00);
    mispredict = 1'b1;
    #1;
    checks++; if ({if_a.data_stall, if_a.flushD, if_a.flushE, if_a.flushM, if_a.stallF} !== 5'b11101)
      begin errors++; $display("FAIL mis_ds: got %b want 11101", {if_a.data_stall, if_a.flushD, if_a.flushE, if_a.flushM, if_a.stallF}); end
    step();
    idle();
  endtask

  task automatic stall_iter();
    set_d(1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00);         // lw r2
    step();
    set_d(1'b1, 1'b0, 5'd0, 1'b0, 5'd2, 5'd0, 2'b01, 2'b01);         // beq on r2
    step();
    step();
  endtask

  task automatic test_counter();
    do_reset();
    for (int k = 0; k < 3; k++) stall_iter();
    #1;
    checks++; if (if_a.stall_cnt !== 4'd6) begin errors++; $display("FAIL cnt_a6: got %0d want 6", if_a.stall_cnt); end
    checks++; if (if_b.stall_cnt !== 32'd3) begin errors++; $display("FAIL cnt_b3: got %0d want 3", if_b.stall_cnt); end
    for (int k = 0; k < 6; k++) stall_iter();
    #1;
    checks++; if (if_a.stall_cnt !== 4'd15) begin errors++; $display("FAIL cnt_sat: got %0d want 15", if_a.stall_cnt); end
    checks++; if (if_b.stall_cnt !== 32'd9) begin errors++; $display("FAIL cnt_b9: got %0d want 9", if_b.stall_cnt); end
    set_d(1'b1, 1'b1, 5'd2, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00);
    step();
    set_d(1'b1, 1'b0, 5'd0, 1'b0, 5'd2, 5'd0, 2'b01, 2'b01);
    #1;
    checks++; if (if_a.data_stall !== 1'b1) begin errors++; $display("FAIL cnt_pre_rst: got %b want 1", if_a.data_stall); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (if_a.stall_cnt !== 4'd0) begin errors++; $display("FAIL cnt_rst: got %0d want 0", if_a.stall_cnt); end
    checks++; if ({if_a.data_stall, if_a.fwdD, if_a.fwdE} !== 9'b0) begin errors++; $display("FAIL cnt_rst_fwd: got %b want 0", {if_a.data_stall, if_a.fwdD, if_a.fwdE}); end
    idle();
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_early_branch();
    test_r0();
    test_exc_under_stall();
    test_simultaneous();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Next-generation hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W).
- Tracks destination-register state for instructions in E, M and W, and generates forwarding selects for NRD read ports, both D-stage (early) and E-stage consumers.
- Generates data stalls, stall/flush vectors and a data-stall performance counter.
- Exceptions that arrive while the pipe is externally stalled are latched and applied once the stall releases, never dropped.

Parameters:
- NRD, 2, number of source-operand read ports per instruction.
- RAW, 5, register address width (register 0 is never tracked).
- LOAD_READY_W, 1, 1: load results forwardable only from W; 0: load results forwardable from M (zero-wait dcache).
- CNT_W, 32, width of the data-stall counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  valid instruction in D.
- issue_wen  in  1  D instruction writes a register.
- issue_wreg  in  RAW  D destination register.
- issue_load  in  1  D instruction is a load or mfc0 (late result).
- rd_reg  in  NRD*RAW  D source registers; port i is bits [i*RAW +: RAW].
- rd_used  in  NRD  port i is read by the D instruction.
- rd_early  in  NRD  port i is consumed in D (branch/jr compare); otherwise consumed in E.
- ext_stall  in  1  i_stall | d_stall | div_stall.
- exception  in  1  exception taken in M.
- mispredict  in  1  branch resolved wrong in D.
- fwdD  out  2*NRD  per port: 00 regfile, 10 from M, 01 from W.
- fwdE  out  2*NRD  per port, same encoding.
- stallF, stallD, stallE, stallM, stallW  out  1 each.
- flushD, flushE, flushM, flushW  out  1 each.
- data_stall  out  1  RAW stall this cycle.
- stall_cnt  out  CNT_W  saturating count of data_stall cycles.

Behaviour:
- **Tracker.** Entries E, M, W each hold {valid, wreg, late}. An entry is ready in stage S if late==0 and S∈{M,W}, or late==1 and S==W; with LOAD_READY_W=0, late entries are also ready in M.
- **Pipe advance.** On a clock with ~ext_stall: W<=M, M<=E, E<=D info. D info is captured only if issue_valid & issue_wen & wreg!=0 & ~data_stall & ~flushE_eff; otherwise E becomes invalid.
- **Freeze.** With ext_stall=1, all entries hold.
- **D-stage match.** For each used port: nearest match by priority E > M > W, with reg!=0.
  - E-consumer: stall if the nearest match is in E and late (load-use).
  - Early consumer: stall if the nearest match is in E (any class), or in M and not ready.
  - fwdD = 10 if the nearest match is in M and ready; 01 if in W; else 00.
- **E-stage consumers.** Port regs/used are registered into E with the same advance/freeze/flush rules. fwdE = 10 if the M match is ready, else 01 if a W match exists, else 00. No stall is generated at E; D-stage stalling guarantees readiness.
- **Flush sources.** Effective exception: exc_eff = (exception | flush_pend) & ~ext_stall.
  - flush_pend sets when exception & ext_stall, and clears when exc_eff.
- **Stall and flush outputs.**
  - data_stall = OR of per-port stalls, gated by issue_valid.
  - stallF = (ext_stall | data_stall) & ~exc_eff.
  - stallD = ext_stall | data_stall.
  - stallE = stallM = stallW = ext_stall.
  - flushD = (mispredict | exc_eff) & ~ext_stall.
  - flushE = (data_stall | mispredict | exc_eff) & ~ext_stall.
  - flushM = flushW = exc_eff.
- **Exception effect on tracker.** exc_eff invalidates E, M and W entries on that clock.
- **Simultaneous events.**
  - exception together with mispredict: exception flush applies (superset).
  - data_stall together with mispredict: flushD and flushE both assert.
- **stall_cnt.** Increments when data_stall & ~ext_stall; saturates at all-ones.
- **Reset.** All entries invalid; flush_pend=0; stall_cnt=0; fwdD=fwdE=0. Stall and flush outputs then reflect only ext_stall (stallD/E/M/W=ext_stall, all flushes 0).
- **Latency.** All stall/flush/forward outputs are combinational from current state and inputs. State updates take effect on the next clock.

Decomposition:
- Shared package holds:
  - fwd encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - the tracker entry struct {valid, wreg, late};
  - stage index constants.
- Sub-module hazard_fwd_match is instantiated once per read port. Inputs: port reg/used/early plus the three entries. Outputs: fwdD and stall.

Test Plan:
- lw r2 issued, then add r3,r2,r4 next cycle → data_stall=1 for one cycle, flushE=1, then fwdE port0=01 (W) with LOAD_READY_W=1; stall_cnt=1.
- add r2 issued, then beq r2,r5 (early) → stall 1 cycle, then fwdD port0=10 (M); same with LOAD_READY_W=0 and lw → stall 1 cycle, then fwdD=10.
- Source r0 with an E entry writing r0 (issue_wreg=0) → no stall, fwd=00.
- ext_stall=1 and exception pulse in the same cycle → no flushes; release ext_stall 3 cycles later → flushD/E/M/W=1 for exactly one cycle, all entries invalid afterwards.
- mispredict and exception in the same cycle, ext_stall=0 → flushD/E/M/W all 1, stallF=0.
- data_stall held for 2^CNT_W cycles (CNT_W overridden to 4) → stall_cnt stays at 15; rst mid-stall → stall_cnt=0 and fwd outputs 0 next cycle.
